image_loader: RTL and testbench

Front-end writer for the simple image processor. Accepts a raster-order RGB pixel stream over a valid/ready handshake and writes each pixel into the input image memory at linear address `y*WIDTH + x`. After the frame it writes a zero pixel at address `SIZE`, the padding location the processing controller reads for out-of-range neighbours. It then raises `load_done` so the controller can start.

---
 rtl/img_pkg.sv | 27 ++
 rtl/image_loader.sv | 172 +++++++++++++++++
 tb/tb_image_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the simple image processor front end.
// Holds default image geometry, the frame size / pad address constants
// used by both the loader and the processing controller, and the loader
// state type.
package img_pkg;

    localparam int IMG_WIDTH  = 128;
    localparam int IMG_HEIGHT = 128;
    localparam int IMG_PIX_W  = 24;

    // Pixel count of a default frame; also the address of the zero pad pixel.
    localparam int          IMG_SIZE     = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [31:0] IMG_PAD_ADDR = 32'(IMG_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } loader_state_t;

    // Pad location for an arbitrary geometry: one past the last pixel.
    function automatic logic [31:0] pad_addr(input int width, input int height);
        return 32'(width * height);
    endfunction

endpackage

// File: rtl/image_loader.sv
// image_loader: writes a raster-order RGB pixel stream into the input image
// memory at y*WIDTH+x, optionally follows with a zero pad pixel at address
// SIZE, then raises load_done for the processing controller.
// Optional feature macro: IMAGE_LOADER_PAD_EN (enables the PAD state and the
// zero write at address SIZE; without it LOAD goes straight to DONE).
module image_loader
    import img_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int PIX_W  = IMG_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [PIX_W-1:0] wr_data,
    output logic             busy,
    output logic             load_done,
    output logic             err
);

    localparam int                SIZE     = WIDTH * HEIGHT;
    localparam int                CNT_W    = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SIZE - 1);
    localparam logic [31:0]       PAD_ADDR = pad_addr(WIDTH, HEIGHT);

    // State following the final accepted beat of a frame.
`ifdef IMAGE_LOADER_PAD_EN
    localparam loader_state_t ST_AFTER_LOAD = ST_PAD;
`else
    localparam loader_state_t ST_AFTER_LOAD = ST_DONE;
`endif

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr_en;
    logic [31:0]       r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_load_done;
    logic              r_err;
    logic              w_in_ready;
    logic              w_busy;
    logic              w_accept;
    logic              w_at_last_pos;
    logic              w_frame_end;
    logic              w_start_ok;

    assign w_accept      = in_valid && w_in_ready;
    assign w_at_last_pos = (r_cnt == CNT_LAST);
    // Either an explicit last beat or the final pixel position closes the frame.
    assign w_frame_end   = w_accept && (in_last || w_at_last_pos);
    assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE and DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_frame_end) begin
                    w_state_next = ST_AFTER_LOAD;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_PAD: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs: ready only while loading, busy through the pad cycle.
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            ST_PAD: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    // Pixel counter, registered write port, sticky error and done flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 32'd0;
            r_wr_data   <= '0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_cnt       <= '0;
                r_load_done <= 1'b0;
                r_err       <= 1'b0;
            end else if (w_accept) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= 32'(r_cnt);
                r_wr_data <= in_data;
                r_cnt     <= r_cnt + CNT_W'(1);
                // Length mismatch: last flagged early, or frame full without last.
                if (in_last != w_at_last_pos) begin
                    r_err <= 1'b1;
                end else begin
                    r_err <= r_err;
                end
`ifdef IMAGE_LOADER_PAD_EN
            end else if (r_state == ST_PAD) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= PAD_ADDR;
                r_wr_data <= '0;
`endif
            end else if (r_state == ST_DONE) begin
                r_load_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign load_done = r_load_done;
    assign err       = r_err;

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader with a 4x3 image (SIZE=12).
// Expected write lists, error flags and done timing are derived per frame
// from the stream that is offered, then compared with what the DUT wrote.
module tb_image_loader;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int PW   = 24;
    localparam int SIZE = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [PW-1:0] wr_data;
    logic          busy;
    logic          load_done;
    logic          err;

    image_loader #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [31:0]   addr;
        logic [PW-1:0] data;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every memory write the DUT issues, tagged with its cycle.
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back('{cyc, wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_writes();
        check("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check("wr_addr", 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            check("wr_data", 64'(obs_q[i].data), 64'(exp_q[i].data));
            check("wr_cycle", 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
        end
    endtask

    // Offer one frame. last_at: beat carrying in_last (-1: none).
    // mode 0: valid held high, data=beat; 1: valid toggles 1,0,...; 2: random.
    // rst_after: assert reset right after this beat is accepted (-1: never).
    task automatic run_frame(input int last_at, input int mode, input int rst_after);
        int  term;
        int  beat;
        int  acc_cyc;
        int  done_cyc;
        int  guard;
        bit  v;
        bit  prev_v;
        bit  ready_seen;
        bit  exp_err;

        term    = (last_at >= 0 && last_at < SIZE - 1) ? last_at : SIZE - 1;
        exp_err = (last_at != SIZE - 1);
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", 64'(in_ready), 64'd1);
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_cleared", 64'(load_done), 64'd0);
        check("err_cleared", 64'(err), 64'd0);

        beat    = 0;
        prev_v  = 1'b0;
        acc_cyc = 0;
        guard   = 0;
        while (beat <= term) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = ~prev_v;
            else                v = 1'($urandom_range(0, 1));
            prev_v   = v;
            in_valid = v;
            in_data  = (mode == 0) ? PW'(beat) : PW'($urandom);
            in_last  = (beat == last_at);
            start    = (mode == 2 && beat == 3);
            check("ready_in_load", 64'(in_ready), 64'd1);
            if (v) begin
                exp_q.push_back('{cyc + 1, 32'(beat), in_data});
                acc_cyc = cyc + 1;
                beat++;
            end
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (guard > 400) begin
                check("beat_timeout", 64'(beat), 64'(term + 1));
                break;
            end
            if (rst_after >= 0 && v && beat - 1 == rst_after) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                rst      = 1'b0;
                @(negedge clk);
                check("rst_wr_en", 64'(wr_en), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_ready", 64'(in_ready), 64'd0);
                check("rst_addr", 64'(wr_addr), 64'd0);
                check("rst_data", 64'(wr_data), 64'd0);
                check("rst_err", 64'(err), 64'd0);
                rst = 1'b1;
                repeat (5) @(negedge clk);
                check("rst_no_done", 64'(load_done), 64'd0);
                check("rst_idle_busy", 64'(busy), 64'd0);
                compare_writes();
                return;
            end
        end

`ifdef IMAGE_LOADER_PAD_EN
        exp_q.push_back('{acc_cyc + 1, 32'(SIZE), '0});
`endif
        // Keep offering an extra beat; it must never be taken.
        in_valid   = 1'b1;
        in_last    = 1'b0;
        in_data    = PW'($urandom);
        done_cyc   = -1;
        ready_seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (in_ready) ready_seen = 1'b1;
            if (load_done && done_cyc < 0) done_cyc = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("ready_after_frame", 64'(ready_seen), 64'd0);
`ifdef IMAGE_LOADER_PAD_EN
        check("done_cycle", 64'(done_cyc), 64'(acc_cyc + 2));
`else
        check("done_cycle", 64'(done_cyc), 64'(acc_cyc + 1));
`endif
        check("load_done", 64'(load_done), 64'd1);
        check("err", 64'(err), 64'(exp_err));
        check("busy_done", 64'(busy), 64'd0);
        compare_writes();
    endtask

    initial begin
        int la;
        // Reset, with start asserted alongside it: reset must win.
        rst   = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("reset_ready", 64'(in_ready), 64'd0);
        check("reset_wr_en", 64'(wr_en), 64'd0);
        check("reset_addr", 64'(wr_addr), 64'd0);
        check("reset_data", 64'(wr_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(load_done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(in_ready), 64'd0);

        run_frame(SIZE - 1, 0, -1);   // full frame, back-to-back
        run_frame(SIZE - 1, 1, -1);   // stalled every other cycle
        run_frame(5, 0, -1);          // early last
        run_frame(-1, 0, -1);         // no last at all
        run_frame(SIZE - 1, 0, 6);    // reset mid-frame
        run_frame(SIZE - 1, 0, -1);   // reload from address 0
        for (int f = 0; f < 4; f++) begin
            la = int'($urandom_range(0, SIZE)) - 1;
            run_frame(la, 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1);
    end

endmodule
